femtorv_mem_arbiter: RTL and testbench
======================================

Name: femtorv_mem_arbiter

Overview:
- Two-master arbiter sharing one femtorv-style memory port (RAM or the IO page) between the CPU (m0) and a secondary master (m1), such as a DMA or display fetcher.
- Each master drives the native single-cycle strobe protocol: rstrb pulse for a read, non-zero wmask pulse for a write, and a busy response.
- The arbiter latches requests, grants the slave port round-robin, and returns busy/rdata to each master.
- Sits between the masters and the femtosoc address decoder.

Parameters:
- ADDR_W, 32, address width of master and slave ports.
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins ties.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous reset, active-low
- m0_addr, m1_addr  in  ADDR_W  master address
- m0_wdata, m1_wdata  in  32  write data
- m0_wmask, m1_wmask  in  4  byte write strobe; non-zero for one cycle = write request
- m0_rstrb, m1_rstrb  in  1  one-cycle read request
- m0_rdata, m1_rdata  out  32  read data, valid in the completion cycle
- m0_rbusy, m1_rbusy  out  1  read pending/in flight
- m0_wbusy, m1_wbusy  out  1  write pending/in flight
- s_addr  out  ADDR_W  slave address
- s_wdata  out  32  slave write data
- s_wmask  out  4  slave write strobe
- s_rstrb  out  1  slave read strobe
- s_rdata  in  32  slave read data
- s_rbusy, s_wbusy  in  1  slave busy
- gnt  out  2  one-hot current owner; 0 when idle

Behaviour:
- Reset, synchronous, while resetn=0:
  - state=IDLE; pending flags, gnt, s_rstrb, s_wmask, all mN_*busy cleared.
  - last_gnt=m1, so m0 wins the first tie.
  - Any in-flight slave transaction is abandoned; no completion is reported after reset.
- Request capture:
  - A strobe at cycle T latches {addr, wdata, wmask, is_read} into that master's holding register at the end of T.
  - In IDLE, or in a completing WAIT cycle, an incoming strobe bypasses the register and is arbitrated in cycle T itself.
- If wmask≠0 and rstrb=1 in the same cycle, the request is a write and the read is dropped.
- A strobe from a master that already has a pending or in-flight request is ignored; the bench flags it as a protocol error.
- States:
  - IDLE: if any request is pending or strobing, pick the winner and go to STROBE; otherwise stay.
  - STROBE: lasts exactly one cycle.
    - s_addr/s_wdata hold the winner's request.
    - s_rstrb=1 for a read, or s_wmask=mask for a write.
    - gnt = winner; always go to WAIT.
  - WAIT: s_rstrb=0, s_wmask=0; s_addr/s_wdata are held.
    - The transaction completes in the first WAIT cycle where the relevant slave busy (s_rbusy or s_wbusy) is 0.
    - On completion: go to STROBE if another request is pending, which gives back-to-back grants with no IDLE bubble; otherwise go to IDLE.
    - The slave must assert busy no earlier than the cycle after the strobe; WAIT never samples busy in STROBE.
- Arbitration:
  - Both masters requesting: with FIXED_PRIO=0 the master ≠ last_gnt wins; with FIXED_PRIO=1, m0 wins.
  - last_gnt updates on entry to STROBE.
- Master responses:
  - mN_rbusy = read pending or in flight for N, excluding the completion cycle.
  - Busy rises in T+1 after the strobe and falls in the completion cycle.
  - mN_wbusy is defined the same way for writes.
  - mN_rdata = s_rdata, routed combinationally; meaningful only in the completion cycle of N's read.
- Latency, zero-wait slave: strobe T → STROBE T+1 → complete T+2. The master sees busy for one cycle.
- A master may issue its next request in its own completion cycle; it is accepted.

Decomposition:
- femtosoc_pkg: state encoding (IDLE/STROBE/WAIT), default ADDR_W, master index localparams.
- Sub-module femtorv_mem_req_latch holds one master's request, pending flag and bypass mux. It is instantiated twice; the arbiter FSM stays in the top module.

Test Plan:
- m0 reads 0x100 at T, zero-wait slave returning 0xDEADBEEF → s_rstrb in T+1; m0_rbusy=1 only in T+1; m0_rdata=0xDEADBEEF in T+2; gnt=01 during T+1..T+2.
- m0 and m1 strobe in the same cycle, FIXED_PRIO=0, after reset → m0 is served first; m1 gets its s_rstrb in the cycle after m0 completes (back-to-back); m1_rbusy stays high throughout.
- Both masters request continuously for 10 transactions → grants alternate m0,m1,m0…; with FIXED_PRIO=1, m1 is starved while m0 keeps requesting.
- m1 writes wmask=0x3, wdata=0x1234 at 0x200; slave holds s_wbusy for 3 cycles → s_wmask=0x3 for exactly one cycle; m1_wbusy falls in the cycle s_wbusy first reads 0 in WAIT.
- Reset mid-WAIT with a pending m1 request → all busy, gnt and s_* strobes are 0 in the cycle after resetn=0; no completion or later strobe is issued for the old requests.
- m0 strobes read and wmask=0xF together → only a write is issued; a second m0 strobe during WAIT is ignored and no extra slave transaction appears.

Source files
------------

// File: rtl/femtosoc_pkg.sv
// Shared definitions for the femtorv two-master memory arbiter.
// Holds the arbiter state encoding, default widths, master indices and the strobe helper.
package femtosoc_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_t;

  function automatic logic is_strobe(input logic rstrb, input logic [3:0] wmask);
    return rstrb | (|wmask);
  endfunction

endpackage

// File: rtl/femtorv_mem_req_latch.sv
// Per-master request holding register with pending flag.
// When nothing is pending, the live strobe is presented directly so it can win the same cycle.
module femtorv_mem_req_latch
  import femtosoc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wmask,
  input  logic              rstrb,
  input  logic              blocked,
  input  logic              take,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_wmask,
  output logic              req_read,
  output logic              pend,
  output logic              pend_read
);

  logic [ADDR_W-1:0] hold_addr;
  logic [31:0]       hold_wdata;
  logic [3:0]        hold_wmask;
  logic              strobe;
  logic              accept;

  assign strobe = is_strobe(rstrb, wmask);
  // A master with a request already queued or in flight cannot stack a second one.
  assign accept = strobe & ~pend & ~blocked;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend       <= 1'b0;
      pend_read  <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_wmask <= '0;
    end else if (take) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend       <= 1'b1;
      pend_read  <= ~|wmask;
      hold_addr  <= addr;
      hold_wdata <= wdata;
      hold_wmask <= wmask;
    end
  end

  assign req_valid = pend | accept;
  assign req_addr  = pend ? hold_addr  : addr;
  assign req_wdata = pend ? hold_wdata : wdata;
  assign req_wmask = pend ? hold_wmask : wmask;
  assign req_read  = pend ? pend_read  : ~|wmask;

endmodule

// File: rtl/femtorv_mem_arbiter.sv
// Two-master arbiter sharing one femtorv-style memory port.
// state     | meaning
// ST_IDLE   | no transaction; any pending or strobing request is granted immediately
// ST_STROBE | one-cycle slave strobe for the granted request
// ST_WAIT   | waiting on slave busy; completion may chain straight into the next grant
module femtorv_mem_arbiter
  import femtosoc_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_rstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_rbusy,
  output logic              m0_wbusy,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_rstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_rbusy,
  output logic              m1_wbusy,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wmask,
  output logic              s_rstrb,
  input  logic [31:0]       s_rdata,
  input  logic              s_rbusy,
  input  logic              s_wbusy,
  output logic [1:0]        gnt
);

  arb_state_t state;
  logic       owner;
  logic       cur_read;
  logic       last_gnt;

  logic              v0, v1;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [31:0]       r0_wdata, r1_wdata;
  logic [3:0]        r0_wmask, r1_wmask;
  logic              r0_read, r1_read;
  logic              pend0, pend1;
  logic              pend_read0, pend_read1;

  logic complete, decide, grant_go, pick_m1;
  logic inflight0, inflight1, done0, done1;
  logic take0, take1;

  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic [3:0]        win_wmask;
  logic              win_read;

  assign complete  = (state == ST_WAIT) & (cur_read ? ~s_rbusy : ~s_wbusy);
  assign decide    = (state == ST_IDLE) | complete;
  assign inflight0 = (state != ST_IDLE) & (owner == M0);
  assign inflight1 = (state != ST_IDLE) & (owner == M1);
  assign done0     = complete & (owner == M0);
  assign done1     = complete & (owner == M1);

  femtorv_mem_req_latch #(.ADDR_W(ADDR_W)) u_req0 (
    .clk       (clk),
    .resetn    (resetn),
    .addr      (m0_addr),
    .wdata     (m0_wdata),
    .wmask     (m0_wmask),
    .rstrb     (m0_rstrb),
    .blocked   (inflight0 & ~done0),
    .take      (take0),
    .req_valid (v0),
    .req_addr  (r0_addr),
    .req_wdata (r0_wdata),
    .req_wmask (r0_wmask),
    .req_read  (r0_read),
    .pend      (pend0),
    .pend_read (pend_read0)
  );

  femtorv_mem_req_latch #(.ADDR_W(ADDR_W)) u_req1 (
    .clk       (clk),
    .resetn    (resetn),
    .addr      (m1_addr),
    .wdata     (m1_wdata),
    .wmask     (m1_wmask),
    .rstrb     (m1_rstrb),
    .blocked   (inflight1 & ~done1),
    .take      (take1),
    .req_valid (v1),
    .req_addr  (r1_addr),
    .req_wdata (r1_wdata),
    .req_wmask (r1_wmask),
    .req_read  (r1_read),
    .pend      (pend1),
    .pend_read (pend_read1)
  );

  // On a tie m1 wins only in round-robin mode when m0 held the previous grant.
  assign pick_m1  = v1 & (~v0 | (~FIXED_PRIO & (last_gnt == M0)));
  assign grant_go = decide & (v0 | v1);
  assign take0    = grant_go & ~pick_m1;
  assign take1    = grant_go & pick_m1;

  assign win_addr  = pick_m1 ? r1_addr  : r0_addr;
  assign win_wdata = pick_m1 ? r1_wdata : r0_wdata;
  assign win_wmask = pick_m1 ? r1_wmask : r0_wmask;
  assign win_read  = pick_m1 ? r1_read  : r0_read;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      owner    <= M0;
      cur_read <= 1'b0;
      last_gnt <= M1;
      gnt      <= 2'b00;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wmask  <= 4'h0;
      s_rstrb  <= 1'b0;
    end else begin
      s_rstrb <= 1'b0;
      s_wmask <= 4'h0;
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (grant_go) begin
            state    <= ST_STROBE;
            owner    <= pick_m1;
            cur_read <= win_read;
            last_gnt <= pick_m1;
            gnt      <= pick_m1 ? 2'b10 : 2'b01;
            s_addr   <= win_addr;
            s_wdata  <= win_wdata;
            s_rstrb  <= win_read;
            s_wmask  <= win_read ? 4'h0 : win_wmask;
          end else if (decide) begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
          end
        end
        ST_STROBE: state <= ST_WAIT;
        default: begin
          state <= ST_IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign m0_rbusy = (pend0 & pend_read0)  | (inflight0 & cur_read  & ~done0);
  assign m0_wbusy = (pend0 & ~pend_read0) | (inflight0 & ~cur_read & ~done0);
  assign m1_rbusy = (pend1 & pend_read1)  | (inflight1 & cur_read  & ~done1);
  assign m1_wbusy = (pend1 & ~pend_read1) | (inflight1 & ~cur_read & ~done1);

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_femtorv_mem_arbiter.sv
// Directed bench for femtorv_mem_arbiter with a slave-strobe scoreboard.
// A second instance with fixed priority shares the reset and sees a zero-wait slave.
module tb_femtorv_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rd;
    logic [1:0]  gnt;
  } txn_t;

  logic        clk, resetn;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb, s_rbusy, s_wbusy;
  logic [1:0]  gnt;

  logic [31:0] fp_m0_addr, fp_m1_addr, fp_zero32;
  logic [3:0]  fp_zero4;
  logic        fp_m0_rstrb, fp_m1_rstrb, fp_zero1;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic        fp_m0_rbusy, fp_m0_wbusy, fp_m1_rbusy, fp_m1_wbusy, fp_s_rstrb;
  logic [3:0]  fp_s_wmask;
  logic [1:0]  fp_gnt;

  int   vectors = 0;
  int   miscompares = 0;
  txn_t exp_q[$];
  txn_t mon_e;
  logic [1:0] fp_seq[$];
  int   cnt0, cnt1, fc0, fc1;

  femtorv_mem_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .gnt(gnt)
  );

  femtorv_mem_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_addr(fp_m0_addr), .m0_wdata(fp_zero32), .m0_wmask(fp_zero4), .m0_rstrb(fp_m0_rstrb),
    .m0_rdata(fp_m0_rdata), .m0_rbusy(fp_m0_rbusy), .m0_wbusy(fp_m0_wbusy),
    .m1_addr(fp_m1_addr), .m1_wdata(fp_zero32), .m1_wmask(fp_zero4), .m1_rstrb(fp_m1_rstrb),
    .m1_rdata(fp_m1_rdata), .m1_rbusy(fp_m1_rbusy), .m1_wbusy(fp_m1_wbusy),
    .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wmask(fp_s_wmask), .s_rstrb(fp_s_rstrb),
    .s_rdata(fp_zero32), .s_rbusy(fp_zero1), .s_wbusy(fp_zero1), .gnt(fp_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // Every slave strobe must match the oldest expected transaction.
  always @(negedge clk) begin
    if (s_rstrb || (s_wmask != 4'h0)) begin
      check("sb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_addr", s_addr, mon_e.addr);
        check("sb_rstrb", 32'(s_rstrb), 32'(mon_e.rd));
        check("sb_wmask", 32'(s_wmask), 32'(mon_e.wmask));
        check("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
        if (!mon_e.rd) check("sb_wdata", s_wdata, mon_e.wdata);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_rstrb = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_rstrb = 1'b0;
    s_rdata = '0; s_rbusy = 1'b0; s_wbusy = 1'b0;
    fp_m0_addr = 32'h800; fp_m1_addr = 32'h900; fp_zero32 = '0; fp_zero4 = '0; fp_zero1 = 1'b0;
    fp_m0_rstrb = 1'b0; fp_m1_rstrb = 1'b0;

    step();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_s_rstrb", 32'(s_rstrb), 32'd0);
    check("rst_s_wmask", 32'(s_wmask), 32'd0);
    check("rst_busy", {28'd0, m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 32'd0);
    step();
    resetn = 1'b1;

    // single read from m0, zero-wait slave
    m0_addr = 32'h100; m0_rstrb = 1'b1; s_rdata = 32'hDEADBEEF;
    exp_q.push_back('{addr:32'h100, wdata:32'h0, wmask:4'h0, rd:1'b1, gnt:2'b01});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_gnt", 32'(gnt), (i == 1 || i == 2) ? 32'd1 : 32'd0);
      check("t1_m0_rbusy", 32'(m0_rbusy), 32'(i == 1));
      if (i == 2) check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
      step();
      m0_rstrb = 1'b0;
    end

    // simultaneous reads after reset: m0 first, m1 back-to-back
    do_reset();
    m0_addr = 32'h110; m1_addr = 32'h210; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    exp_q.push_back('{addr:32'h110, wdata:32'h0, wmask:4'h0, rd:1'b1, gnt:2'b01});
    exp_q.push_back('{addr:32'h210, wdata:32'h0, wmask:4'h0, rd:1'b1, gnt:2'b10});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_gnt", 32'(gnt), (i == 0 || i == 5) ? 32'd0 : ((i <= 2) ? 32'd1 : 32'd2));
      check("t2_m0_rbusy", 32'(m0_rbusy), 32'(i == 1));
      check("t2_m1_rbusy", 32'(m1_rbusy), 32'(i >= 1 && i <= 3));
      step();
      m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    end

    // continuous requests: each master restrobes whenever it is not busy
    cnt0 = 0; cnt1 = 0; fc0 = 0; fc1 = 0;
    for (int c = 0; c < 40; c++) begin
      m0_rstrb = !m0_rbusy && (cnt0 < 5);
      m1_rstrb = !m1_rbusy && (cnt1 < 5);
      if (m0_rstrb) begin
        m0_addr = 32'h300 + 32'(cnt0 * 4);
        exp_q.push_back('{addr:m0_addr, wdata:32'h0, wmask:4'h0, rd:1'b1, gnt:2'b01});
        cnt0++;
      end
      if (m1_rstrb) begin
        m1_addr = 32'h400 + 32'(cnt1 * 4);
        exp_q.push_back('{addr:m1_addr, wdata:32'h0, wmask:4'h0, rd:1'b1, gnt:2'b10});
        cnt1++;
      end
      fp_m0_rstrb = !fp_m0_rbusy && (fc0 < 5);
      fp_m1_rstrb = !fp_m1_rbusy && (fc1 < 1);
      if (fp_m0_rstrb) fc0++;
      if (fp_m1_rstrb) fc1++;
      @(negedge clk);
      if (fp_s_rstrb) fp_seq.push_back(fp_gnt);
      step();
    end
    m0_rstrb = 1'b0; m1_rstrb = 1'b0; fp_m0_rstrb = 1'b0; fp_m1_rstrb = 1'b0;
    check("t3_drain", 32'(exp_q.size()), 32'd0);
    check("t3_fp_len", 32'(fp_seq.size()), 32'd6);
    for (int i = 0; i < fp_seq.size(); i++)
      check("t3_fp_gnt", 32'(fp_seq[i]), (i < 5) ? 32'd1 : 32'd2);

    // m1 write with slave write-busy for three cycles
    m1_addr = 32'h200; m1_wdata = 32'h1234; m1_wmask = 4'h3;
    exp_q.push_back('{addr:32'h200, wdata:32'h1234, wmask:4'h3, rd:1'b0, gnt:2'b10});
    for (int i = 0; i < 7; i++) begin
      s_wbusy = (i >= 2 && i <= 4);
      @(negedge clk);
      check("t4_m1_wbusy", 32'(m1_wbusy), 32'(i >= 1 && i <= 4));
      check("t4_s_wmask", 32'(s_wmask), (i == 1) ? 32'd3 : 32'd0);
      check("t4_gnt", 32'(gnt), (i >= 1 && i <= 5) ? 32'd2 : 32'd0);
      step();
      m1_wmask = 4'h0;
    end
    s_wbusy = 1'b0;

    // reset while m0 waits on the slave and m1 has a request queued
    m0_addr = 32'h500; m0_rstrb = 1'b1;
    exp_q.push_back('{addr:32'h500, wdata:32'h0, wmask:4'h0, rd:1'b1, gnt:2'b01});
    step();
    m0_rstrb = 1'b0; m1_addr = 32'h510; m1_rstrb = 1'b1;
    step();
    m1_rstrb = 1'b0; s_rbusy = 1'b1;
    @(negedge clk);
    check("t5_m0_rbusy_wait", 32'(m0_rbusy), 32'd1);
    check("t5_m1_rbusy_pend", 32'(m1_rbusy), 32'd1);
    step();
    resetn = 1'b0;
    step();
    @(negedge clk);
    check("t5_gnt", 32'(gnt), 32'd0);
    check("t5_strobes", {27'd0, s_wmask, s_rstrb}, 32'd0);
    check("t5_busy", {28'd0, m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 32'd0);
    step();
    resetn = 1'b1; s_rbusy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_after_busy", {30'd0, m0_rbusy, m1_rbusy}, 32'd0);
      check("t5_after_gnt", 32'(gnt), 32'd0);
      step();
    end

    // read+write strobe together becomes a write; restrobe during WAIT is ignored
    m0_addr = 32'h600; m0_wdata = 32'hCAFEF00D; m0_wmask = 4'hF; m0_rstrb = 1'b1;
    exp_q.push_back('{addr:32'h600, wdata:32'hCAFEF00D, wmask:4'hF, rd:1'b0, gnt:2'b01});
    for (int i = 0; i < 9; i++) begin
      s_wbusy = (i == 2);
      if (i == 2) begin
        m0_addr = 32'h700; m0_rstrb = 1'b1;
      end
      @(negedge clk);
      check("t6_m0_wbusy", 32'(m0_wbusy), 32'(i == 1 || i == 2));
      check("t6_m0_rbusy", 32'(m0_rbusy), 32'd0);
      if (i >= 4) check("t6_gnt_idle", 32'(gnt), 32'd0);
      step();
      m0_rstrb = 1'b0; m0_wmask = 4'h0;
    end
    s_wbusy = 1'b0;
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
